// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - byte-stream command parser driving single Wishbone classic cycles
//
// Purpose:
//   Accepts a compact command stream on an 8-bit valid/ready channel:
//     'W' (0x57) + 4 address bytes + 4 data bytes
//     'R' (0x52) + 4 address bytes
//   Multi-byte fields arrive MSB first. Each command issues one 32-bit Wishbone
//   classic cycle. The result goes back on an 8-bit valid/ready response channel:
//     'K' (0x4B) on ack, followed by 4 read-data bytes (MSB first) for reads
//     'T' (0x54) on timeout, status byte only
//     'E' (0x45) for an unknown opcode, with no bus cycle issued
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid_i/cmd_data_i    command byte in
//   cmd_ready_o               command byte accepted on valid && ready
//   rsp_valid_o/rsp_data_o    response byte out
//   rsp_ready_i               response byte consumed on valid && ready
//   wbm_cyc_o/wbm_stb_o       Wishbone cycle/strobe (always identical)
//   wbm_we_o, wbm_sel_o       write enable, byte select (4'hF during a cycle)
//   wbm_adr_o, wbm_dat_o      address, write data
//   wbm_dat_i, wbm_ack_i      read data, slave acknowledge
module uart_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  input  logic [7:0]  cmd_data_i,
  output logic        cmd_ready_o,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  input  logic        rsp_ready_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [7:0]  OP_WRITE   = 8'h57;
  localparam logic [7:0]  OP_READ    = 8'h52;
  localparam logic [7:0]  ST_ACK     = 8'h4B;
  localparam logic [7:0]  ST_TIMEOUT = 8'h54;
  localparam logic [7:0]  ST_ERROR   = 8'h45;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RSP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        rst_done;     // holds cmd_ready low until one edge after reset
  logic        is_write;
  logic [1:0]  byte_cnt;     // byte position within the address/data field
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rd_q;
  logic [7:0]  status_q;
  logic [2:0]  rsp_idx;      // response byte currently presented
  logic [2:0]  rsp_last;     // index of the final response byte
  logic [15:0] tmo_cnt;

  logic        cmd_fire;
  logic        rsp_fire;
  logic        opcode_ok;
  logic        field_done;
  logic        tmo_expired;
  logic        rsp_done;

  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign opcode_ok   = (cmd_data_i == OP_WRITE) || (cmd_data_i == OP_READ);
  assign field_done  = cmd_fire && (byte_cnt == 2'd3);
  assign tmo_expired = (tmo_cnt == TMO_LAST);
  assign rsp_done    = rsp_fire && (rsp_idx == rsp_last);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nx = opcode_ok ? S_ADDR : S_RSP;
        end
      end
      S_ADDR: begin
        if (field_done) begin
          state_nx = is_write ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (field_done) begin
          state_nx = S_BUS;
        end
      end
      S_BUS: begin
        // ack takes priority over an expiring timeout in the same cycle
        if (wbm_ack_i || tmo_expired) begin
          state_nx = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_done) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode; everything is a function of registered state except the
  // reset gate on cmd_ready, which must drop while reset is held.
  always_comb begin
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = 8'h00;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_sel_o   = 4'h0;
    case (state)
      S_IDLE, S_ADDR, S_WDATA: begin
        cmd_ready_o = rst_done && !wb_rst_i;
      end
      S_BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = is_write;
        wbm_sel_o = 4'hF;
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        case (rsp_idx)
          3'd0:    rsp_data_o = status_q;
          3'd1:    rsp_data_o = rd_q[31:24];
          3'd2:    rsp_data_o = rd_q[23:16];
          3'd3:    rsp_data_o = rd_q[15:8];
          default: rsp_data_o = rd_q[7:0];
        endcase
      end
      default: ;
    endcase
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  // Datapath: field shifting, bus result capture, response sequencing
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rst_done <= 1'b0;
      is_write <= 1'b0;
      byte_cnt <= 2'd0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      rd_q     <= 32'h0;
      status_q <= 8'h00;
      rsp_idx  <= 3'd0;
      rsp_last <= 3'd0;
      tmo_cnt  <= 16'h0;
    end else begin
      rst_done <= 1'b1;
      // the counter only runs in BUS, so it is zero on every BUS entry
      if (state != S_BUS) begin
        tmo_cnt <= 16'h0;
      end
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            is_write <= (cmd_data_i == OP_WRITE);
            byte_cnt <= 2'd0;
            rsp_idx  <= 3'd0;
            rsp_last <= 3'd0;
            if (!opcode_ok) begin
              status_q <= ST_ERROR;
            end
          end
        end
        S_ADDR: begin
          if (cmd_fire) begin
            adr_q    <= {adr_q[23:0], cmd_data_i};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WDATA: begin
          if (cmd_fire) begin
            dat_q    <= {dat_q[23:0], cmd_data_i};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_BUS: begin
          if (wbm_ack_i) begin
            rd_q     <= wbm_dat_i;
            status_q <= ST_ACK;
            rsp_idx  <= 3'd0;
            rsp_last <= is_write ? 3'd0 : 3'd4;
          end else if (tmo_expired) begin
            status_q <= ST_TIMEOUT;
            rsp_idx  <= 3'd0;
            rsp_last <= 3'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RSP: begin
          if (rsp_fire && !rsp_done) begin
            rsp_idx <= rsp_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb/tb_uart_wb_master.sv - directed bench for uart_wb_master with a simple Wishbone slave
module tb_uart_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack = 1'b0;

  int passed = 0;
  int total  = 0;

  // slave behaviour knobs, written only by the main sequence
  int          ack_wait = 0;
  logic        ack_en   = 1'b1;
  logic        ack_idle = 1'b0;
  logic [31:0] rd_value = 32'h0;

  // monitor state, written only by the monitor processes
  int          cyc_total = 0;
  int          rsp_total = 0;
  int          unstable  = 0;
  int          strobe_bad = 0;
  int          edge_no   = 0;
  int          wait_cnt  = 0;
  logic        in_cyc    = 1'b0;
  logic [31:0] cap_adr   = 32'h0;
  logic [31:0] cap_dat   = 32'h0;
  logic        cap_we    = 1'b0;
  logic [3:0]  cap_sel   = 4'h0;

  always #5 clk = ~clk;

  uart_wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_data_i  (cmd_data),
    .cmd_ready_o (cmd_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack)
  );

  // Slave: acks on the (ack_wait+1)-th cycle of cyc; drives ack_idle while idle.
  always @(negedge clk) begin
    if (cyc && ack_en) begin
      ack      <= (wait_cnt == ack_wait);
      wait_cnt <= wait_cnt + 1;
    end else begin
      ack      <= cyc ? 1'b0 : ack_idle;
      wait_cnt <= 0;
    end
  end

  assign dat_i = (ack && cyc) ? rd_value : 32'h0;

  // Bus monitor: cycle counts, captured bus fields, stability within a cycle
  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    in_cyc  <= cyc;
    if (rsp_valid) begin
      rsp_total <= rsp_total + 1;
    end
    if (cyc) begin
      cyc_total <= cyc_total + 1;
      cap_adr   <= adr;
      cap_dat   <= dat_o;
      cap_we    <= we;
      cap_sel   <= sel;
      if (in_cyc && (adr !== cap_adr || dat_o !== cap_dat || we !== cap_we)) begin
        unstable <= unstable + 1;
      end
      if (stb !== 1'b1 || sel !== 4'hF) begin
        strobe_bad <= strobe_bad + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready) begin
      @(posedge clk);
      @(negedge clk);
    end else begin
      chk("cmd_ready_bound", {31'h0, cmd_ready}, 32'h1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31:24], int'($urandom_range(0, maxgap)));
      v = {v[23:0], 8'h00};
    end
  endtask

  // Waits for rsp_valid, holds rsp_ready low for 'stall' cycles checking the
  // byte stays put, then consumes it. Returns at the negedge after transfer.
  task automatic recv_byte(output logic [7:0] b, output int waited,
                           output int t_valid, input int stall);
    logic [7:0] held;
    waited = 0;
    b = 8'h00;
    while (!rsp_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    t_valid = edge_no;
    if (!rsp_valid) begin
      chk("rsp_valid_bound", {31'h0, rsp_valid}, 32'h1);
      return;
    end
    held = rsp_data;
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_stall_hold", {23'h0, rsp_valid, rsp_data}, {23'h0, 1'b1, held});
    end
    rsp_ready = 1'b1;
    b = rsp_data;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] exp_rd;
    int          w;
    int          tv;
    int          t0;
    int          c0;
    int          r0;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data",  {24'h0, rsp_data}, 32'h0);
    chk("rst_cyc_stb_we", {29'h0, cyc, stb, we}, 32'h0);
    chk("rst_sel", {28'h0, sel}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_before_first_edge", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("cmd_ready_after_reset", {31'h0, cmd_ready}, 32'h1);

    // write, zero-wait slave; ack held high while idle must be ignored
    ack_en = 1'b1; ack_wait = 0; ack_idle = 1'b1;
    c0 = cyc_total;
    send_byte(8'h57, 0);
    t0 = edge_no;
    send_word(32'h30001004, 0);
    send_word(32'hDEADBEEF, 0);
    chk("wr_bus_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("wr_bus_cyc", {30'h0, cyc, stb}, 32'h3);
    ack_idle = 1'b0;
    recv_byte(b, w, tv, 0);
    chk("wr_status", {24'h0, b}, 32'h4B);
    // status first transferable at edge tv+1; opcode accepted at edge t0
    chk("wr_round_trip", 32'(tv + 1 - t0), 32'd10);
    chk("wr_cyc_cycles", 32'(cyc_total - c0), 32'd1);
    chk("wr_adr", cap_adr, 32'h30001004);
    chk("wr_dat", cap_dat, 32'hDEADBEEF);
    chk("wr_we", {31'h0, cap_we}, 32'h1);
    chk("wr_sel", {28'h0, cap_sel}, 32'hF);
    chk("wr_rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    // read, ack after 3 wait cycles
    ack_wait = 3; rd_value = 32'h12345678;
    c0 = cyc_total;
    send_byte(8'h52, 0);
    send_word(32'h30000008, 0);
    recv_byte(b, w, tv, 0);
    chk("rd_status", {24'h0, b}, 32'h4B);
    exp_rd = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, w, tv, 0);
      chk("rd_byte", {24'h0, b}, {24'h0, exp_rd[31:24]});
      chk("rd_byte_back_to_back", 32'(w), 32'd0);
      exp_rd = {exp_rd[23:0], 8'h00};
    end
    chk("rd_cyc_cycles", 32'(cyc_total - c0), 32'd4);
    chk("rd_we", {31'h0, cap_we}, 32'h0);
    chk("rd_adr", cap_adr, 32'h30000008);
    chk("rd_rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    // timeout: slave never acks
    ack_en = 1'b0;
    c0 = cyc_total;
    send_byte(8'h52, 0);
    send_word(32'h30000010, 0);
    recv_byte(b, w, tv, 0);
    chk("tmo_status", {24'h0, b}, 32'h54);
    chk("tmo_cyc_cycles", 32'(cyc_total - c0), 32'd8);
    chk("tmo_rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    // bad opcode, then a read with command gaps and response backpressure
    ack_en = 1'b1; ack_wait = 1; rd_value = 32'hCAFEF00D;
    c0 = cyc_total;
    send_byte(8'h41, 0);
    recv_byte(b, w, tv, 0);
    chk("bad_status", {24'h0, b}, 32'h45);
    chk("bad_no_cycle", 32'(cyc_total - c0), 32'd0);
    chk("bad_rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    send_byte(8'h52, int'($urandom_range(0, 3)));
    send_word(32'h30000004, 3);
    recv_byte(b, w, tv, 5);
    chk("bp_status", {24'h0, b}, 32'h4B);
    exp_rd = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, w, tv, 5);
      chk("bp_byte", {24'h0, b}, {24'h0, exp_rd[31:24]});
      exp_rd = {exp_rd[23:0], 8'h00};
    end
    chk("bp_cyc_cycles", 32'(cyc_total - c0), 32'd2);
    chk("bp_adr", cap_adr, 32'h30000004);
    chk("bp_rsp_done", {31'h0, rsp_valid}, 32'h0);

    // reset while in BUS
    ack_en = 1'b0;
    r0 = rsp_total;
    send_byte(8'h52, 0);
    send_word(32'h30000020, 0);
    chk("rst_bus_cyc_before", {31'h0, cyc}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_bus_cyc_dropped", {30'h0, cyc, stb}, 32'h0);
    chk("rst_bus_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_bus_no_response", 32'(rsp_total - r0), 32'd0);

    // reset after two address bytes of a write
    send_byte(8'h57, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    #1;
    chk("rst_addr_cmd_ready_now", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("rst_addr_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_addr_cyc", {30'h0, cyc, stb}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr_no_response", 32'(rsp_total - r0), 32'd0);

    // a complete write afterwards must parse from a clean state
    ack_en = 1'b1; ack_wait = 0;
    c0 = cyc_total;
    send_byte(8'h57, 0);
    send_word(32'h11223344, 1);
    send_word(32'h01020304, 1);
    recv_byte(b, w, tv, 2);
    chk("post_rst_status", {24'h0, b}, 32'h4B);
    chk("post_rst_adr", cap_adr, 32'h11223344);
    chk("post_rst_dat", cap_dat, 32'h01020304);
    chk("post_rst_we", {31'h0, cap_we}, 32'h1);
    chk("post_rst_cyc_cycles", 32'(cyc_total - c0), 32'd1);

    chk("bus_fields_stable", 32'(unstable), 32'd0);
    chk("stb_sel_with_cyc", 32'(strobe_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Byte-stream to Wishbone master bridge: parses a compact command stream (opcode, address, optional write data) arriving on an 8-bit valid/ready channel and issues single 32-bit Wishbone classic cycles as bus initiator. It returns status and read data on an 8-bit response channel. It sits between a host UART byte link and the user-area Wishbone fabric, so the UART slave array can be driven from an external host without the management core.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a cycle may wait for `wbm_ack_i` before it is abandoned. Range is 1..65535.
- wb_clk_i  input  1  single clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command byte valid.
- cmd_data_i  input  8  command byte.
- cmd_ready_o  output  1  bridge accepts a command byte.
- rsp_valid_o  output  1  response byte valid.
- rsp_data_o  output  8  response byte.
- rsp_ready_i  input  1  consumer accepts the response byte.
- wbm_cyc_o, wbm_stb_o  output  1  Wishbone cycle and strobe, always driven identically.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  4  byte select; always 4'hF while a cycle is active.
- wbm_adr_o  output  32  address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  slave acknowledge.

## Operation
- **Handshake:** a byte transfers on a rising edge with valid&&ready. The producer must hold valid and data until the transfer.
- **Command format:**
  - Opcode 0x57 ('W'): opcode, then 4 address bytes, then 4 data bytes.
  - Opcode 0x52 ('R'): opcode, then 4 address bytes.
  - Multi-byte fields are sent MSB first.
- **Response format:**
  - Status byte 0x4B ('K') on ack, or 0x54 ('T') on timeout.
  - Successful read: status byte followed by 4 data bytes, MSB first.
  - Write, or read that timed out: status byte only.
  - Unknown opcode: single byte 0x45 ('E'), then back to IDLE. No bus cycle is issued.
- **State machine:**
  - IDLE: cmd_ready=1. Opcode W/R goes to ADDR. Any other opcode goes to RSP with 'E'.
  - ADDR: cmd_ready=1. Shifts 4 bytes into wbm_adr_o with a 2-bit byte counter. After the 4th byte, go to WDATA for W or BUS for R.
  - WDATA: cmd_ready=1. Shifts 4 bytes into wbm_dat_o, then go to BUS.
  - BUS: cmd_ready=0. cyc/stb=1, we=1 for W, sel=4'hF.
    - On ack: capture wbm_dat_i, set status 'K', go to RSP.
    - On timeout: set status 'T', go to RSP.
  - RSP: cmd_ready=0. Emits the response bytes with a byte counter, then go to IDLE.
- **Stability:** wbm_adr_o, wbm_dat_o and wbm_we_o are stable for the whole BUS state.
- **wbm_ack_i outside BUS** is ignored.
- **Timeout counter:** 16-bit, cleared on BUS entry, increments each BUS cycle without ack. The timeout fires when the count equals TIMEOUT_CYCLES-1 with no ack. If ack and expiry occur in the same cycle, ack wins.
- **Reset:**
  - Reset in any state returns to IDLE at the next edge.
  - cyc/stb drop at that edge; no response byte is produced for the interrupted command.
  - Partially received commands are discarded.

## Timing
- **Reset values:**
  - cmd_ready_o=0 while wb_rst_i is high; it becomes 1 one cycle after reset deasserts.
  - rsp_valid_o=0, rsp_data_o=0.
  - cyc/stb/we=0, sel=0, adr=0, dat_o=0.
- **Bus start:** the last command byte accepted at edge N gives cyc/stb=1 in the cycle after edge N.
- **Bus end:** ack sampled high at edge M gives cyc/stb=0 and rsp_valid_o=1 with the status byte, both in the cycle after edge M.
  - Minimum write round trip, opcode accept to status valid: 10 cycles with a zero-wait slave.
- **Response bytes:** rsp_valid_o stays high with stable data until rsp_ready_i. The next byte is valid in the cycle immediately after a transfer, so full throughput is 1 byte per cycle.
- **Return to IDLE:** cmd_ready_o=1 in the cycle after the last response byte transfers.
- **Timeout:** with no ack, cyc/stb are high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- **Write, zero-wait slave:** bytes 57 30 00 10 04 DE AD BE EF -> one cycle with adr=0x30001004, dat_o=0xDEADBEEF, we=1, sel=F, cyc/stb high 1 cycle; response 4B.
- **Read, slave acks after 3 wait cycles with 0x12345678:** bytes 52 30 00 00 08 -> cyc/stb high 4 cycles, we=0; response 4B 12 34 56 78.
- **Timeout, TIMEOUT_CYCLES=8, slave never acks:** read command -> cyc/stb high exactly 8 cycles; response 54 only. A next command is then accepted normally.
- **Bad opcode:** byte 0x41 -> response 45, no cyc. Then 52 + address completes normally.
- **Backpressure:** random gaps on cmd_valid_i and rsp_ready_i held low for 5 cycles per byte during a read -> data bytes unchanged while stalled, order 4B,b3..b0, no drop or duplication.
- **Reset mid-operation:** assert wb_rst_i during BUS and again after 2 address bytes -> cyc/stb=0 and cmd_ready=0 during reset, no response byte. The next full write command executes with a correct address, proving no stale bytes remain.
